// File: rtl/pc_fetch_unit.sv
// Fetch-stage program counter: issues one word address per cycle into the
// program window, applies stall/jump/branch redirects, halts on an illegal next PC.
module pc_fetch_unit #(
   parameter logic [31:0] PROG_BASE = 32'h31B0,
   parameter logic [31:0] PROG_LAST = 32'h35AF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic        jump,
   input  logic [25:0] jump_target,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   output logic [31:0] pc_out,
   output logic [31:0] pc_plus4,
   output logic        fetch_valid,
   output logic        fault,
   output logic [31:0] fault_addr
);

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } state_t;

   state_t      state;
   logic [31:0] cand;
   logic        cand_ok;

   assign pc_plus4 = pc_out + 32'd4;

   // Priority: stall > jump > branch > sequential.
   always_comb begin
      cand = pc_plus4;
      if (stall)             cand = pc_out;
      else if (jump)         cand = {pc_plus4[31:28], jump_target, 2'b00};
      else if (branch_taken) cand = branch_target;
   end

   assign cand_ok = (cand[1:0] == 2'b00) && (cand >= PROG_BASE) &&
                    (cand <= (PROG_LAST - 32'd3));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= BOOT;
         pc_out      <= PROG_BASE;
         fetch_valid <= 1'b0;
         fault       <= 1'b0;
         fault_addr  <= 32'd0;
      end else begin
         case (state)
            BOOT: begin
               state       <= RUN;
               fetch_valid <= 1'b1;
            end
            RUN: begin
               if (cand_ok) begin
                  pc_out <= cand;
               end else begin
                  // Keep the last legal PC; report the rejected one.
                  state       <= HALT;
                  fetch_valid <= 1'b0;
                  fault       <= 1'b1;
                  fault_addr  <= cand;
               end
            end
            HALT: begin
               state <= HALT;
            end
            default: begin
               state       <= HALT;
               fetch_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule
